multdiv_ctrl: RTL and testbench

Sequencer for the multi-cycle mult/div unit in the 5-stage pipeline. Accepts a mult or div issue from the X stage and pulses the unit's start control. While the operation is outstanding it stalls dependent X-stage instructions. When the unit reports ready, it claims the P/W writeback slot so the unit's result (or exception) enters the P/W latch in place of the normal pipeline result.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/multdiv_hazard.sv | 26 ++
 rtl/multdiv_ctrl.sv | 161 ++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: mult/div sequencer state encoding and rstatus constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        WB    = 2'd3
    } md_state_e;

    localparam int unsigned RSTATUS_REG      = 30;
    localparam int unsigned RSTATUS_MULT_EXC = 4;
    localparam int unsigned RSTATUS_DIV_EXC  = 5;

endpackage

// File: rtl/multdiv_hazard.sv
// Flags an X-stage instruction that touches the register still pending in the mult/div unit.
module multdiv_hazard
    import cpu_pkg::*;
#(
    parameter int unsigned RW = 5
) (
    input  logic          active,
    input  logic [RW-1:0] pend_rd,
    input  logic [RW-1:0] x_rs,
    input  logic [RW-1:0] x_rt,
    input  logic [RW-1:0] x_rd,
    input  logic          x_uses_rs,
    input  logic          x_uses_rt,
    input  logic          x_wb,
    output logic          hazard_c
);

    // r0 is never a real dependency, so a pending write to it never stalls.
    always_comb begin
        hazard_c = active && (pend_rd != '0) &&
                   ((x_uses_rs && (x_rs == pend_rd)) ||
                    (x_uses_rt && (x_rt == pend_rd)) ||
                    (x_wb      && (x_rd == pend_rd)));
    end

endmodule

// File: rtl/multdiv_ctrl.sv
// Mult/div sequencer: starts the unit, stalls dependents, and steals the P/W slot on completion.
module multdiv_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned RW      = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_mult,
    input  logic          issue_div,
    input  logic [RW-1:0] issue_rd,
    input  logic [RW-1:0] x_rs,
    input  logic [RW-1:0] x_rt,
    input  logic          x_uses_rs,
    input  logic          x_uses_rt,
    input  logic [RW-1:0] x_rd,
    input  logic          x_wb,
    input  logic          md_ready,
    input  logic          md_exception,
    output logic          ctrl_mult,
    output logic          ctrl_div,
    output logic          busy,
    output logic          stall,
    output logic          wb_sel,
    output logic          wb_we,
    output logic [RW-1:0] wb_rd,
    output logic          wb_exc,
    output logic          wb_is_div
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    md_state_e     state_q, state_d;
    logic [RW-1:0] pend_rd_q, pend_rd_d;
    logic          pend_div_q, pend_div_d;
    logic          pend_exc_q, pend_exc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          ctrl_mult_q, ctrl_mult_d;
    logic          ctrl_div_q, ctrl_div_d;
    logic          busy_q, busy_d;
    logic          wb_sel_q, wb_sel_d;
    logic          wb_we_q, wb_we_d;
    logic [RW-1:0] wb_rd_q, wb_rd_d;
    logic          wb_exc_q, wb_exc_d;
    logic          wb_is_div_q, wb_is_div_d;

    logic          hazard_c;
    logic          structural_c;

    multdiv_hazard #(.RW(RW)) u_hazard (
        .active    (state_q != IDLE),
        .pend_rd   (pend_rd_q),
        .x_rs      (x_rs),
        .x_rt      (x_rt),
        .x_rd      (x_rd),
        .x_uses_rs (x_uses_rs),
        .x_uses_rt (x_uses_rt),
        .x_wb      (x_wb),
        .hazard_c  (hazard_c)
    );

    // Next state, pending fields, and the output values that go with the next state.
    always_comb begin
        state_d    = state_q;
        pend_rd_d  = pend_rd_q;
        pend_div_d = pend_div_q;
        pend_exc_d = pend_exc_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (issue_mult || issue_div) begin
                    pend_rd_d  = issue_rd;
                    pend_div_d = !issue_mult;
                    pend_exc_d = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = CW'(cnt_q + 1'b1);
                if (md_ready) begin
                    pend_exc_d = md_exception;
                    state_d    = WB;
                end else if (cnt_q == CNT_LAST) begin
                    pend_exc_d = 1'b1;
                    state_d    = WB;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d != IDLE);
        ctrl_mult_d = (state_d == START) && !pend_div_d;
        ctrl_div_d  = (state_d == START) && pend_div_d;
        wb_sel_d    = (state_d == WB);
        wb_we_d     = wb_sel_d && (pend_exc_d || (pend_rd_d != '0));
        wb_rd_d     = wb_sel_d ? (pend_exc_d ? RW'(RSTATUS_REG) : pend_rd_d) : '0;
        wb_exc_d    = wb_sel_d && pend_exc_d;
        wb_is_div_d = wb_sel_d && pend_div_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_rd_q   <= '0;
            pend_div_q  <= 1'b0;
            pend_exc_q  <= 1'b0;
            cnt_q       <= '0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            busy_q      <= 1'b0;
            wb_sel_q    <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_exc_q    <= 1'b0;
            wb_is_div_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_rd_q   <= pend_rd_d;
            pend_div_q  <= pend_div_d;
            pend_exc_q  <= pend_exc_d;
            cnt_q       <= cnt_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
            busy_q      <= busy_d;
            wb_sel_q    <= wb_sel_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_exc_q    <= wb_exc_d;
            wb_is_div_q <= wb_is_div_d;
        end
    end

    // A new issue while busy cannot be accepted; hold the front end until IDLE.
    always_comb begin
        structural_c = (issue_mult || issue_div) && (state_q != IDLE);
        stall        = hazard_c || structural_c || (state_q == WB);
    end

    assign ctrl_mult = ctrl_mult_q;
    assign ctrl_div  = ctrl_div_q;
    assign busy      = busy_q;
    assign wb_sel    = wb_sel_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_exc    = wb_exc_q;
    assign wb_is_div = wb_is_div_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed scenarios plus random traffic against a timeline model.
module tb_multdiv_ctrl;

    localparam int unsigned TIMEOUT = 40;
    localparam int unsigned RW      = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_mult, issue_div;
    logic [RW-1:0] issue_rd;
    logic [RW-1:0] x_rs, x_rt, x_rd;
    logic          x_uses_rs, x_uses_rt, x_wb;
    logic          md_ready, md_exception;
    logic          ctrl_mult, ctrl_div, busy, stall;
    logic          wb_sel, wb_we, wb_exc, wb_is_div;
    logic [RW-1:0] wb_rd;

    multdiv_ctrl #(.TIMEOUT(TIMEOUT), .RW(RW)) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_mult   (issue_mult),
        .issue_div    (issue_div),
        .issue_rd     (issue_rd),
        .x_rs         (x_rs),
        .x_rt         (x_rt),
        .x_uses_rs    (x_uses_rs),
        .x_uses_rt    (x_uses_rt),
        .x_rd         (x_rd),
        .x_wb         (x_wb),
        .md_ready     (md_ready),
        .md_exception (md_exception),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .busy         (busy),
        .stall        (stall),
        .wb_sel       (wb_sel),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_exc       (wb_exc),
        .wb_is_div    (wb_is_div)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Timeline model: one outstanding op, described by the cycle its START occupies
    // and (once known) the cycle of its writeback.
    bit            chk_en    = 1'b0;
    bit            m_act     = 1'b0;
    int            m_start   = 0;
    int            m_wb      = -1;
    bit            m_div     = 1'b0;
    bit            m_exc     = 1'b0;
    logic [RW-1:0] m_rd      = '0;
    int            m_accepts = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_act  = 1'b0;
            chk_en = 1'b1;
        end else if (!m_act) begin
            if (issue_mult || issue_div) begin
                m_act   = 1'b1;
                m_start = cyc + 1;
                m_div   = !issue_mult;
                m_rd    = issue_rd;
                m_wb    = -1;
                m_accepts++;
            end
        end else if (m_wb < 0) begin
            if (cyc >= m_start + 1) begin
                if (md_ready) begin
                    m_wb  = cyc + 1;
                    m_exc = md_exception;
                end else if (cyc == m_start + int'(TIMEOUT)) begin
                    m_wb  = cyc + 1;
                    m_exc = 1'b1;
                end
            end
        end else if (cyc == m_wb) begin
            m_act = 1'b0;
        end
        cyc++;
    end

    // Compare every output mid-cycle against what the model says this cycle should look like.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            bit in_wb, haz, strc;
            in_wb = m_act && (m_wb == cyc);
            haz   = m_act && (m_rd != 0) &&
                    ((x_uses_rs && x_rs == m_rd) || (x_uses_rt && x_rt == m_rd) ||
                     (x_wb && x_rd == m_rd));
            strc  = m_act && (issue_mult || issue_div);
            check_eq("busy",      32'(busy),      32'(m_act));
            check_eq("ctrl_mult", 32'(ctrl_mult), 32'(m_act && cyc == m_start && !m_div));
            check_eq("ctrl_div",  32'(ctrl_div),  32'(m_act && cyc == m_start && m_div));
            check_eq("wb_sel",    32'(wb_sel),    32'(in_wb));
            check_eq("wb_we",     32'(wb_we),     32'(in_wb && (m_exc || m_rd != 0)));
            check_eq("wb_rd",     32'(wb_rd),     in_wb ? (m_exc ? 32'd30 : 32'(m_rd)) : 32'd0);
            check_eq("wb_exc",    32'(wb_exc),    32'(in_wb && m_exc));
            check_eq("wb_is_div", 32'(wb_is_div), 32'(in_wb && m_div));
            check_eq("stall",     32'(stall),     32'(haz || strc || in_wb));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        issue_mult = 0; issue_div = 0; issue_rd = '0;
        x_rs = '0; x_rt = '0; x_rd = '0;
        x_uses_rs = 0; x_uses_rt = 0; x_wb = 0;
        md_ready = 0; md_exception = 0;
    endtask

    initial begin
        int base, waited, wb_seen, busy_len;
        reset = 1'b1;
        clear_inputs();
        step(); step();
        reset = 1'b0;
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_wb_sel", 32'(wb_sel), 32'd0);
        step();

        // Mult to r5, ready on the third RUN cycle, with hazard probes while pending.
        issue_mult = 1; issue_rd = 5'd5;
        step(); clear_inputs();                                 // START
        busy_len = 0;
        step(); x_rs = 5'd5; x_uses_rs = 1;                     // RUN1: real hazard
        if (busy) busy_len++;
        step(); clear_inputs(); x_rt = 5'd5; x_uses_rt = 0;     // RUN2: unused operand
        if (busy) busy_len++;
        step(); clear_inputs(); md_ready = 1;                   // RUN3
        if (busy) busy_len++;
        step(); clear_inputs();                                 // WB
        if (busy) busy_len++;
        step();                                                 // IDLE
        if (busy) busy_len++;
        check_eq("mult_busy_run_wb_cycles", 32'(busy_len), 32'd4);
        step();

        // Div by zero to r7.
        issue_div = 1; issue_rd = 5'd7;
        step(); clear_inputs();
        step(); md_ready = 1; md_exception = 1;
        step(); clear_inputs();
        step(); step();

        // Pending r0 never creates a hazard stall.
        issue_mult = 1; issue_rd = 5'd0;
        step(); clear_inputs(); x_uses_rs = 1; x_uses_rt = 1; x_wb = 1;
        step(); step(); md_ready = 1;
        step(); clear_inputs();
        step(); step();

        // Timeout: md_ready never arrives.
        issue_mult = 1; issue_rd = 5'd3;
        step(); clear_inputs();
        repeat (TIMEOUT + 4) step();

        // Structural: second mult held from RUN until it is accepted.
        issue_mult = 1; issue_rd = 5'd4;
        step(); clear_inputs();
        step(); issue_mult = 1; issue_rd = 5'd9;
        step(); md_ready = 1;
        step(); md_ready = 0;
        base = m_accepts; waited = 0;
        while (m_accepts == base && waited < 10) begin
            step(); waited++;
        end
        check_eq("struct_accept_wait", 32'(waited < 10), 32'd1);
        clear_inputs();
        step(); step(); md_ready = 1;
        step(); clear_inputs();
        step(); step();

        // Reset during RUN; a later md_ready must not produce a writeback.
        issue_div = 1; issue_rd = 5'd6;
        step(); clear_inputs();
        step(); step();
        reset = 1;
        step(); reset = 0; md_ready = 1;
        wb_seen = 0;
        repeat (6) begin
            step();
            if (wb_sel) wb_seen++;
        end
        check_eq("reset_mid_run_no_wb", 32'(wb_seen), 32'd0);
        clear_inputs();
        step();

        // Random traffic.
        repeat (800) begin
            issue_mult   = ($urandom_range(0, 5) == 0);
            issue_div    = ($urandom_range(0, 5) == 0);
            issue_rd     = RW'($urandom_range(0, 7));
            x_rs         = RW'($urandom_range(0, 7));
            x_rt         = RW'($urandom_range(0, 7));
            x_rd         = RW'($urandom_range(0, 7));
            x_uses_rs    = 1'($urandom_range(0, 1));
            x_uses_rt    = 1'($urandom_range(0, 1));
            x_wb         = 1'($urandom_range(0, 1));
            md_ready     = ($urandom_range(0, 3) == 0);
            md_exception = 1'($urandom_range(0, 1));
            reset        = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 0;
        clear_inputs();
        repeat (TIMEOUT + 5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
